// File: rtl/systolic_array_ctrl_pkg.sv
// Shared definitions for the systolic array sequencer: FSM state encoding,
// quantisation mode constants and a counter-width helper.
package systolic_array_ctrl_pkg;

    // Job sequencing states; encodings are fixed so debug probes stay stable.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_W = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // PE arithmetic modes broadcast on pe_quantize_mode.
    localparam logic QMODE_INT8 = 1'b0;
    localparam logic QMODE_INT4 = 1'b1;

    // Width of a counter that indexes `rows` items, never narrower than 1 bit.
    function automatic int row_cnt_width(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

endpackage

// File: rtl/systolic_array_ctrl_act_skew_buf.sv
// Input skew buffer for the array west edge: lane r is delayed by r+1 cycles
// so that activations meet the diagonal wavefront of a weight-stationary array.
module systolic_array_ctrl_act_skew_buf #(
    parameter int ROWS       = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic [ROWS*DATA_WIDTH-1:0] in_data,
    output logic [ROWS*DATA_WIDTH-1:0] out_data
);

    for (genvar r = 0; r < ROWS; r++) begin : g_lane
        logic [DATA_WIDTH-1:0] stage [r+1];

        // Lane r delay line: stage 0 captures the lane, later stages shift it on.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i <= r; i++) stage[i] <= '0;
            end else if (clr) begin
                for (int i = 0; i <= r; i++) stage[i] <= '0;
            end else begin
                stage[0] <= in_data[r*DATA_WIDTH +: DATA_WIDTH];
                for (int i = 1; i <= r; i++) stage[i] <= stage[i-1];
            end
        end

        assign out_data[r*DATA_WIDTH +: DATA_WIDTH] = stage[r];
    end

endmodule

// File: rtl/systolic_array_ctrl.sv
// Sequencer for a weight-stationary ROWS x COLS systolic array: loads weight
// rows, streams skewed activation vectors, tracks per-column output validity,
// drains the pipeline and pulses done.
//
// Handshakes: a beat transfers on a rising clk edge where valid and ready are
// both 1. ready is a registered output that depends only on the FSM state,
// never on valid; the upstream buffer must hold data stable while valid=1 and
// ready=0.
module systolic_array_ctrl
    import systolic_array_ctrl_pkg::*;
#(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int DATA_WIDTH = 8,
    parameter int VEC_W      = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic [VEC_W-1:0]           num_vectors,
    input  logic                       quant_mode_cfg,
    input  logic                       wt_valid,
    output logic                       wt_ready,
    input  logic [COLS*DATA_WIDTH-1:0] wt_data,
    input  logic                       act_valid,
    output logic                       act_ready,
    input  logic [ROWS*DATA_WIDTH-1:0] act_data,
    output logic                       pe_enable,
    output logic [ROWS-1:0]            pe_load_weight,
    output logic [COLS*DATA_WIDTH-1:0] pe_weight_bus,
    output logic                       pe_quantize_mode,
    output logic [ROWS*DATA_WIDTH-1:0] pe_act_bus,
    output logic [COLS-1:0]            out_valid,
    output logic                       busy,
    output logic                       done
);

    localparam int RCW      = row_cnt_width(ROWS);
    localparam int PIPE_LEN = ROWS + COLS;
    localparam int DCW      = $clog2(PIPE_LEN + 1);

    localparam logic [RCW-1:0] LAST_ROW   = RCW'(ROWS - 1);
    localparam logic [DCW-1:0] LAST_DRAIN = DCW'(PIPE_LEN - 1);

    state_t                      state;
    logic   [RCW-1:0]            row_cnt;
    logic   [VEC_W-1:0]          vec_cnt;
    logic   [VEC_W-1:0]          num_lat;
    logic   [DCW-1:0]            drain_cnt;
    logic   [PIPE_LEN-1:0]       valid_pipe;
    logic                        quant_lat;
    logic                        wt_acc;
    logic                        act_acc;
    logic   [ROWS*DATA_WIDTH-1:0] skew_in;

    assign wt_acc  = wt_valid & wt_ready;
    assign act_acc = act_valid & act_ready;

    // Idle lanes carry zeros so the array sees no stale activations.
    assign skew_in = act_acc ? act_data : '0;

    // Column c becomes valid ROWS+c+1 cycles after the accept that fed it.
    assign out_valid        = valid_pipe[PIPE_LEN-1:ROWS];
    assign pe_quantize_mode = quant_lat;

    systolic_array_ctrl_act_skew_buf #(
        .ROWS       (ROWS),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_act_skew_buf (
        .clk      (clk),
        .rst      (rst),
        .clr      (abort),
        .in_data  (skew_in),
        .out_data (pe_act_bus)
    );

    // Job FSM with all control outputs registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            row_cnt        <= '0;
            vec_cnt        <= '0;
            num_lat        <= '0;
            drain_cnt      <= '0;
            valid_pipe     <= '0;
            quant_lat      <= QMODE_INT8;
            wt_ready       <= 1'b0;
            act_ready      <= 1'b0;
            pe_enable      <= 1'b0;
            pe_load_weight <= '0;
            pe_weight_bus  <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            pe_load_weight <= '0;
            done           <= 1'b0;
            if (abort) begin
                // Abort wins over every transition and leaves no done pulse.
                state      <= ST_IDLE;
                row_cnt    <= '0;
                vec_cnt    <= '0;
                num_lat    <= '0;
                drain_cnt  <= '0;
                valid_pipe <= '0;
                quant_lat  <= QMODE_INT8;
                wt_ready   <= 1'b0;
                act_ready  <= 1'b0;
                pe_enable  <= 1'b0;
                pe_weight_bus <= '0;
                busy       <= 1'b0;
            end else begin
                valid_pipe <= {valid_pipe[PIPE_LEN-2:0], act_acc};
                pe_enable  <= 1'b0;
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            busy <= 1'b1;
                            if (num_vectors != '0) begin
                                num_lat   <= num_vectors;
                                quant_lat <= quant_mode_cfg;
                                row_cnt   <= '0;
                                vec_cnt   <= '0;
                                wt_ready  <= 1'b1;
                                state     <= ST_LOAD_W;
                            end else begin
                                done  <= 1'b1;
                                state <= ST_DONE;
                            end
                        end
                    end
                    ST_LOAD_W: begin
                        if (wt_acc) begin
                            pe_load_weight <= ROWS'(1) << row_cnt;
                            pe_weight_bus  <= wt_data;
                            pe_enable      <= 1'b1;
                            if (row_cnt == LAST_ROW) begin
                                row_cnt   <= '0;
                                wt_ready  <= 1'b0;
                                act_ready <= 1'b1;
                                state     <= ST_STREAM;
                            end else begin
                                row_cnt <= row_cnt + RCW'(1);
                            end
                        end
                    end
                    ST_STREAM: begin
                        pe_enable <= 1'b1;
                        if (act_acc) begin
                            vec_cnt <= vec_cnt + VEC_W'(1);
                            if (vec_cnt + VEC_W'(1) == num_lat) begin
                                act_ready <= 1'b0;
                                drain_cnt <= '0;
                                state     <= ST_DRAIN;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        // Hold the array enabled until the last column has emptied.
                        if (drain_cnt == LAST_DRAIN) begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            pe_enable <= 1'b1;
                            drain_cnt <= drain_cnt + DCW'(1);
                        end
                    end
                    ST_DONE: begin
                        busy      <= 1'b0;
                        vec_cnt   <= '0;
                        drain_cnt <= '0;
                        quant_lat <= QMODE_INT8;
                        state     <= ST_IDLE;
                    end
                    default: begin
                        busy      <= 1'b0;
                        wt_ready  <= 1'b0;
                        act_ready <= 1'b0;
                        state     <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Directed bench for systolic_array_ctrl with hand-computed expectations.
module tb_systolic_array_ctrl;

    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int DW    = 8;
    localparam int VEC_W = 16;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic                 abort = 1'b0;
    logic [VEC_W-1:0]     num_vectors = '0;
    logic                 quant_mode_cfg = 1'b0;
    logic                 wt_valid = 1'b0;
    logic                 wt_ready;
    logic [COLS*DW-1:0]   wt_data = '0;
    logic                 act_valid = 1'b0;
    logic                 act_ready;
    logic [ROWS*DW-1:0]   act_data = '0;
    logic                 pe_enable;
    logic [ROWS-1:0]      pe_load_weight;
    logic [COLS*DW-1:0]   pe_weight_bus;
    logic                 pe_quantize_mode;
    logic [ROWS*DW-1:0]   pe_act_bus;
    logic [COLS-1:0]      out_valid;
    logic                 busy;
    logic                 done;

    int n_checks = 0;
    int n_pass   = 0;

    systolic_array_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW), .VEC_W(VEC_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .num_vectors(num_vectors), .quant_mode_cfg(quant_mode_cfg),
        .wt_valid(wt_valid), .wt_ready(wt_ready), .wt_data(wt_data),
        .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data),
        .pe_enable(pe_enable), .pe_load_weight(pe_load_weight),
        .pe_weight_bus(pe_weight_bus), .pe_quantize_mode(pe_quantize_mode),
        .pe_act_bus(pe_act_bus), .out_valid(out_valid),
        .busy(busy), .done(done)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else n_pass++;
    endtask

    // Advance to just after the next active edge; outputs are stable there.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [VEC_W-1:0] nv, input logic q);
        start = 1'b1; num_vectors = nv; quant_mode_cfg = q;
        tick();
        start = 1'b0;
    endtask

    task automatic send_weight(input logic [31:0] w);
        wt_valid = 1'b1; wt_data = w;
        tick();
        wt_valid = 1'b0; wt_data = '0;
    endtask

    task automatic load_all_rows();
        send_weight(32'h01020304);
        send_weight(32'h05060708);
        send_weight(32'h090A0B0C);
        send_weight(32'h0D0E0F10);
    endtask

    logic [31:0] vecs [3];
    logic [31:0] exp_act;
    logic [3:0]  exp_ov;
    logic        saw_done;
    int          found_k;
    int          ov3_k;

    initial begin
        vecs[0] = 32'h0A0A0A0A;
        vecs[1] = 32'h05050505;
        vecs[2] = 32'hFDFDFDFD;

        // Reset state.
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_wt_ready", wt_ready, 0);
        check("rst_act_ready", act_ready, 0);
        check("rst_pe_enable", pe_enable, 0);
        check("rst_load", pe_load_weight, 0);
        check("rst_act_bus", pe_act_bus, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_qmode", pe_quantize_mode, 0);
        rst = 1'b0;
        tick();

        // Weight load with a 2-cycle gap, INT4 mode latched.
        start_job(16'd3, 1'b1);
        check("ld_wt_ready", wt_ready, 1);
        check("ld_busy", busy, 1);
        check("ld_qmode", pe_quantize_mode, 1);
        check("ld_idle_load", pe_load_weight, 0);
        send_weight(32'h01020304);
        check("ld_row0", pe_load_weight, 4'b0001);
        check("ld_bus0", pe_weight_bus, 32'h01020304);
        check("ld_en0", pe_enable, 1);
        send_weight(32'h05060708);
        check("ld_row1", pe_load_weight, 4'b0010);
        check("ld_bus1", pe_weight_bus, 32'h05060708);
        tick();
        check("ld_gap0", pe_load_weight, 0);
        tick();
        check("ld_gap1", pe_load_weight, 0);
        send_weight(32'h090A0B0C);
        check("ld_row2", pe_load_weight, 4'b0100);
        check("ld_bus2", pe_weight_bus, 32'h090A0B0C);
        send_weight(32'h0D0E0F10);
        check("ld_row3", pe_load_weight, 4'b1000);
        check("ld_bus3", pe_weight_bus, 32'h0D0E0F10);
        check("st_act_ready", act_ready, 1);
        check("st_wt_ready", wt_ready, 0);

        // Stream 3 vectors back-to-back from cycle T; cfg flips but mode must hold.
        quant_mode_cfg = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (k < 3) begin act_valid = 1'b1; act_data = vecs[k]; end
            else begin act_valid = 1'b0; act_data = '0; end
            tick();
            exp_act = '0;
            for (int r = 0; r < ROWS; r++) begin
                int idx;
                idx = (k + 1) - 1 - r;
                if (idx >= 0 && idx <= 2) exp_act[r*DW +: DW] = vecs[idx][r*DW +: DW];
            end
            for (int c = 0; c < COLS; c++)
                exp_ov[c] = ((k + 1) - 5 - c >= 0) && ((k + 1) - 5 - c <= 2);
            check($sformatf("st_act_bus_t%0d", k + 1), pe_act_bus, exp_act);
            check($sformatf("st_out_valid_t%0d", k + 1), out_valid, exp_ov);
            check($sformatf("st_done_t%0d", k + 1), done, (k + 1 == 11));
            check($sformatf("st_act_ready_t%0d", k + 1), act_ready, (k + 1 <= 2));
            check($sformatf("st_pe_enable_t%0d", k + 1), pe_enable, (k + 1 <= 10));
            check($sformatf("st_busy_t%0d", k + 1), busy, (k + 1 <= 11));
            check($sformatf("st_qmode_t%0d", k + 1), pe_quantize_mode, (k + 1 <= 11));
        end
        act_valid = 1'b0;

        // Zero-vector job completes immediately.
        start_job(16'd0, 1'b0);
        check("zero_done", done, 1);
        check("zero_busy", busy, 1);
        check("zero_wt_ready", wt_ready, 0);
        tick();
        check("zero_done_clr", done, 0);
        check("zero_idle", busy, 0);
        check("zero_wt_ready2", wt_ready, 0);

        // Abort after two weight beats, then reload from row 0.
        start_job(16'd2, 1'b0);
        send_weight(32'hAAAA0001);
        send_weight(32'hAAAA0002);
        check("ab_row1", pe_load_weight, 4'b0010);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_busy", busy, 0);
        check("ab_wt_ready", wt_ready, 0);
        check("ab_load", pe_load_weight, 0);
        check("ab_pe_enable", pe_enable, 0);
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done) saw_done = 1'b1;
            tick();
        end
        check("ab_no_done", saw_done, 0);
        start_job(16'd2, 1'b0);
        send_weight(32'hBBBB0001);
        check("ab_reload_row0", pe_load_weight, 4'b0001);
        check("ab_reload_bus", pe_weight_bus, 32'hBBBB0001);
        abort = 1'b1;
        tick();

        // Abort together with start in IDLE keeps the controller idle.
        start = 1'b1; num_vectors = 16'd4;
        tick();
        start = 1'b0; abort = 1'b0;
        check("ab_start_busy", busy, 0);
        check("ab_start_wt_ready", wt_ready, 0);
        tick();
        check("ab_start_busy2", busy, 0);

        // Async reset in the middle of streaming.
        start_job(16'd5, 1'b0);
        load_all_rows();
        act_valid = 1'b1; act_data = 32'h11223344;
        tick();
        act_data = 32'h55667788;
        tick();
        act_valid = 1'b0; act_data = '0;
        check("mr_act_bus_pre", pe_act_bus, 32'h00003388);
        #2 rst = 1'b1;
        #1;
        check("mr_busy", busy, 0);
        check("mr_load", pe_load_weight, 0);
        check("mr_out_valid", out_valid, 0);
        check("mr_act_bus", pe_act_bus, 0);
        check("mr_act_ready", act_ready, 0);
        #1 rst = 1'b0;
        tick();

        // Normal single-vector job after reset: done 9 cycles after the accept.
        start_job(16'd1, 1'b0);
        check("rs_wt_ready", wt_ready, 1);
        load_all_rows();
        check("rs_row3", pe_load_weight, 4'b1000);
        act_valid = 1'b1; act_data = 32'h01010101;
        tick();
        act_valid = 1'b0; act_data = '0;
        found_k = -1;
        ov3_k = -1;
        for (int k = 1; k <= 20; k++) begin
            if (done && found_k < 0) found_k = k;
            if (out_valid[3] && ov3_k < 0) ov3_k = k;
            tick();
        end
        check("rs_done_lat", found_k, 9);
        check("rs_ov3_lat", ov3_k, 8);
        check("rs_idle", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/systolic_array_ctrl.md
Name: systolic_array_ctrl

Overview:
Sequencer for a weight-stationary ROWS x COLS array of systolic PEs. It loads one weight row per handshake beat into the array with per-row load strobes. It then streams activation vectors through an input skew buffer, tracks output validity per column, drains the pipeline and signals completion. It sits between the weight/activation buffers and the PE array edge.

Parameters:
ROWS, 4, PE rows (activation lanes, weight rows)
COLS, 4, PE columns (psum outputs)
DATA_WIDTH, 8, activation/weight width
VEC_W, 16, width of the vector-count field

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start  in  1  job start pulse; ignored unless idle
abort  in  1  synchronous job abort
num_vectors  in  VEC_W  activation vectors per job, latched at start
quant_mode_cfg  in  1  0=INT8, 1=INT4, latched at start
wt_valid  in  1  weight row beat valid
wt_ready  out  1  controller accepts weight row
wt_data  in  COLS*DATA_WIDTH  one weight row, column 0 in LSBs
act_valid  in  1  activation vector beat valid
act_ready  out  1  controller accepts activation vector
act_data  in  ROWS*DATA_WIDTH  one vector, row 0 in LSBs
pe_enable  out  1  PE array enable
pe_load_weight  out  ROWS  one-hot row weight-load strobe
pe_weight_bus  out  COLS*DATA_WIDTH  registered weight row to array
pe_quantize_mode  out  1  mode to all PEs
pe_act_bus  out  ROWS*DATA_WIDTH  skewed activations to the array west edge
out_valid  out  COLS  per-column psum_out valid at the array south edge
busy  out  1  job in progress
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, rst=1): FSM=IDLE, counters=0, skew and valid pipelines cleared. All outputs 0.
- FSM states: IDLE, LOAD_W, STREAM, DRAIN, DONE. busy=1 in every state except IDLE.
- IDLE:
  - start=1 and num_vectors!=0: latch num_vectors and quant_mode_cfg, go to LOAD_W.
  - start=1 and num_vectors==0: go to DONE directly.
- LOAD_W:
  - wt_ready=1.
  - On each accepted beat, in the next cycle pe_load_weight=(1<<row_cnt), pe_weight_bus=wt_data and pe_enable=1. Then row_cnt increments.
  - Gaps in wt_valid give pe_load_weight=0 with no row advance.
  - The accept of row ROWS-1 moves the FSM to STREAM.
- STREAM:
  - act_ready=1.
  - Accepted beat: lane r of act_data appears on pe_act_bus lane r exactly 1+r cycles later.
  - A cycle with no accepted beat injects zeros with valid=0.
  - vec_cnt increments per accept. The accept that makes vec_cnt==num_vectors moves the FSM to DRAIN.
- DRAIN:
  - act_ready=0. Zeros are injected.
  - Lasts exactly ROWS+COLS cycles, then the FSM goes to DONE.
- DONE: done=1 for one cycle, then IDLE.
- pe_enable=1 throughout STREAM and DRAIN.
- pe_quantize_mode holds the latched value from start to DONE. Changes on quant_mode_cfg mid-job have no effect.
- out_valid[c] equals the accept strobe delayed by ROWS+c+1 cycles.
  - For a last accept at cycle T, the final out_valid[COLS-1] pulse is at T+ROWS+COLS and done is at T+ROWS+COLS+1.
- Simultaneous events:
  - start while busy is ignored.
  - abort has priority over every transition. Next cycle: IDLE, pipelines and counters cleared, no done pulse.
  - abort together with start in IDLE: stay IDLE.
- Counters are VEC_W bits and never wrap: num_vectors is at most 2^VEC_W-1.
- Row counter width is $clog2(ROWS), with a minimum of 1 bit.

Decomposition:
- Shared package/header: FSM state encodings (IDLE=0 … DONE=4, 3 bits) and the QMODE_INT8/QMODE_INT4 constants.
- One sub-module, act_skew_buf: per-lane delay line of depth r+1 for lane r, with a synchronous clear and an async rst. It is parameterised by ROWS and DATA_WIDTH.

Test Plan:
1. Start a job, assert rst mid-STREAM -> busy, pe_load_weight, out_valid and pe_act_bus all 0 in the same cycle; after release, start works normally.
2. ROWS=4, weight rows 0x01020304, 0x05060708, 0x090A0B0C, 0x0D0E0F10 with a 2-cycle wt_valid gap after row 1 -> pe_load_weight 0001, 0010, 0100, 1000, each one cycle after its accept, with the matching pe_weight_bus; 0000 during the gap.
3. num_vectors=3, back-to-back vectors 0x0A0A0A0A, 0x05050505, 0xFDFDFDFD accepted at T..T+2 -> lane r carries 0x0A at T+1+r; out_valid[c] pulses at T+5+c..T+7+c; done at T+2+9.
4. num_vectors=0 with start at cycle T -> done=1 at T+1, wt_ready never asserted.
5. Start with quant_mode_cfg=1, drive it to 0 during STREAM -> pe_quantize_mode stays 1 until DONE, then returns to 0.
6. Assert abort after 2 weight beats -> IDLE next cycle, no done pulse; a following start with 4 weight rows reloads beginning from row 0 (pe_load_weight=0001).
